// File: rtl/macc_arbiter.sv
// macc_arbiter: round-robin arbiter sharing one multiply-add-subtract unit; define MACC_ARBITER_STATS_EN for the handshake counter
module macc_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int ADD_K = 17,
  parameter int SUB_K = 21
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         REQ_VALID,
  output logic [NREQ-1:0]         REQ_READY,
  input  logic [NREQ*W-1:0]       REQ_A,
  input  logic [NREQ*W-1:0]       REQ_B,
  output logic                    RES_VALID,
  input  logic                    RES_READY,
  output logic [W-1:0]            RES_DATA,
  output logic [$clog2(NREQ)-1:0] RES_ID,
  output logic [15:0]             STAT_COUNT
);
  localparam int IW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0, COMPUTE = 2'd1, HOLD = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] last_q, last_d, id_q, id_d, res_id_q, res_id_d, gnt_idx;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic res_valid_q, res_valid_d, armed_q, gnt_found, xfer;
  // round-robin search; scanning downward lets the nearest requester after last_q win
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--)
      if (REQ_VALID[IW'((int'(last_q) + k) % NREQ)]) begin
        gnt_found = 1'b1;
        gnt_idx = IW'((int'(last_q) + k) % NREQ);
      end
  end
  assign REQ_READY = (armed_q && state_q == IDLE && gnt_found) ? NREQ'(1) << gnt_idx : '0;
  assign xfer = |REQ_READY;
  // capture operands on a grant, compute in COMPUTE, hold the result until taken
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    res_id_d = res_id_q;
    if (state_q == IDLE && xfer) begin
      state_d = COMPUTE;
      last_d = gnt_idx;
      id_d = gnt_idx;
      a_d = REQ_A[gnt_idx*W +: W];
      b_d = REQ_B[gnt_idx*W +: W];
    end else if (state_q == COMPUTE) begin
      state_d = HOLD;
      res_valid_d = 1'b1;
      res_data_d = W'(a_q * b_q) + W'(ADD_K) - W'(SUB_K);
      res_id_d = id_q;
    end else if (state_q != IDLE && (state_q != HOLD || RES_READY)) begin
      state_d = IDLE;
      res_valid_d = 1'b0;
    end
  end
  // state registers; armed_q keeps REQ_READY low until the first edge after reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q <= IW'(NREQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_id_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_id_q <= res_id_d;
      armed_q <= 1'b1;
    end
  end
  assign RES_VALID = res_valid_q;
  assign RES_DATA = res_data_q;
  assign RES_ID = res_id_q;
`ifdef MACC_ARBITER_STATS_EN
  logic [15:0] stat_q, stat_d;
  // saturating count of result handshakes
  always_comb stat_d = (res_valid_q && RES_READY && stat_q != 16'hFFFF) ? stat_q + 16'd1 : stat_q;
  // counter register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stat_q <= '0;
    else stat_q <= stat_d;
  end
  assign STAT_COUNT = stat_q;
`else
  assign STAT_COUNT = '0;
`endif
endmodule

// File: tb/tb_macc_arbiter.sv
// tb_macc_arbiter: table vectors, directed corner sequences and random traffic against a transaction-level model
module tb_macc_arbiter;
  logic CLK = 1'b0, RST = 1'b1;
  logic [3:0] req_valid = '0, req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic res_valid, res_ready = 1'b0;
  logic [7:0] res_data;
  logic [1:0] res_id;
  logic [15:0] stat_count;
  int checks = 0, failures = 0;
`ifdef MACC_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  macc_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_A(req_a), .REQ_B(req_b), .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_DATA(res_data), .RES_ID(res_id), .STAT_COUNT(stat_count)
  );
  always #5 CLK = ~CLK;
  typedef struct { int id; int a; int b; int exp; } vec_t;
  vec_t vecs[7];
  int ptr, pa, pb, pid, md, mid, cnt, cyc;
  bit busy, computing, mv, armed, rec;
  int rec_id[$], rec_cyc[$];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask
  function automatic int ref_res(int a, int b);
    return ((a * b) % 256 + 17 - 21 + 256) % 256;
  endfunction
  function automatic int model_grant();
    for (int k = 1; k <= 4; k++)
      if (req_valid[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction
  task automatic model_reset();
    ptr = 3; busy = 0; computing = 0; mv = 0; armed = 0; cnt = 0;
  endtask
  task automatic step();
    int g;
    bit hs;
    #1;
    g = (!busy && armed) ? model_grant() : -1;
    check("req_ready", req_ready, g >= 0 ? (1 << g) : 0);
    hs = mv && res_ready;
    @(posedge CLK);
    cyc++;
    armed = 1;
    if (hs) begin
      mv = 0; busy = 0;
      cnt = cnt < 65535 ? cnt + 1 : cnt;
    end else if (computing) begin
      computing = 0; mv = 1; md = ref_res(pa, pb); mid = pid;
      if (rec) begin rec_id.push_back(mid); rec_cyc.push_back(cyc); end
    end else if (g >= 0) begin
      busy = 1; computing = 1; ptr = g; pid = g;
      pa = int'(req_a[g*8 +: 8]); pb = int'(req_b[g*8 +: 8]);
    end
    #1;
    check("res_valid", res_valid, mv);
    if (mv) begin
      check("res_data", res_data, md);
      check("res_id", res_id, mid);
    end
    check("stat_count", stat_count, STATS ? cnt : 0);
  endtask
  task automatic do_reset();
    RST = 1;
    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_stat", stat_count, 0);
    @(posedge CLK);
    #1;
    RST = 0;
    model_reset();
  endtask
  initial begin
    int k, held;
    vecs[0] = '{0, 3, 5, 11};
    vecs[1] = '{1, 16, 16, 252};
    vecs[2] = '{2, 1, 4, 0};
    vecs[3] = '{3, 255, 255, 253};
    vecs[4] = '{0, 7, 3, 17};
    vecs[5] = '{1, 0, 0, 252};
    vecs[6] = '{2, 128, 2, 252};
    model_reset();
    req_valid = 4'b1111;
    do_reset();
    step();
    req_valid = '0;
    step();
    res_ready = 1;
    for (int i = 0; i < 7; i++) begin
      req_valid = 4'(1 << vecs[i].id);
      req_a[vecs[i].id*8 +: 8] = 8'(vecs[i].a);
      req_b[vecs[i].id*8 +: 8] = 8'(vecs[i].b);
      k = 0;
      while (!mv && k < 10) begin step(); k++; end
      check("vec_latency", k, 2);
      check("vec_data", res_data, vecs[i].exp);
      check("vec_id", res_id, vecs[i].id);
      req_valid = '0;
      step();
      if (i == 4) check("stat_after_5", stat_count, STATS ? 5 : 0);
    end
    do_reset();
    req_valid = 4'b1111;
    rec = 1;
    for (int i = 0; i < 16; i++) step();
    rec = 0;
    if (rec_id.size() < 5) check("rot_count", rec_id.size(), 5);
    else
      for (int i = 0; i < 5; i++) begin
        check("rot_id", rec_id[i], i % 4);
        if (i > 0) check("rot_spacing", rec_cyc[i] - rec_cyc[i-1], 3);
      end
    req_valid = '0;
    do_reset();
    res_ready = 0;
    req_valid = 4'b0010;
    k = 0;
    while (!mv && k < 10) begin step(); k++; end
    check("hold_reached", mv, 1);
    req_valid = 4'b0001;
    held = int'(res_data);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_data", res_data, held);
      check("hold_ready", req_ready, 0);
    end
    res_ready = 1;
    step();
    #1;
    check("hold_next_grant", req_ready, 4'b0001);
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    req_valid = 4'b0100;
    req_a = 32'h00_09_00_00;
    req_b = 32'h00_09_00_00;
    step();
    step();
    RST = 1;
    #1;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    @(posedge CLK);
    #1;
    RST = 0;
    model_reset();
    req_valid = 4'b0101;
    step();
    #1;
    check("midrst_grant0", req_ready, 4'b0001);
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a = $urandom();
      req_b = $urandom();
      res_ready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
